viterbi_decoder: RTL

//  Hard-decision Viterbi decoder for the K=3, rate-1/2 convolutional code (G0=111, G1=101).

---
 rtl/viterbi_decoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2 code (G0=111, G1=101).
// Four trellis states, register-exchange survivors, metrics normalised every symbol.
// Optional feature macro: VITERBI_ERR_CNT_EN enables the re-encode / corrected-bit counter;
// without it err_count is tied to zero and no delay line or re-encoder exists.
module viterbi_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5,
  parameter int ERR_W    = 16
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             clr,
  input  logic             sym_valid,
  input  logic [1:0]       sym_in,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [PM_W-1:0]   PM_MAX    = '1;
  localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state;
  logic [FILL_W-1:0]   fill;
  logic [PM_W-1:0]     pm [4];
  logic [TB_DEPTH-1:0] surv [4];

  logic [PM_W-1:0]     cand0 [4];
  logic [PM_W-1:0]     cand1 [4];
  logic [PM_W-1:0]     pm_acc [4];
  logic [PM_W-1:0]     pm_norm [4];
  logic [TB_DEPTH-1:0] surv_new [4];
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;
  logic [FILL_W-1:0]   fill_next;
  logic                full_next;
  logic                dec_bit;

  // Hamming distance between the received symbol and the branch output of pred p with input d
  function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic [1:0] p,
                                               input logic d);
    logic c0;
    logic c1;
    c0 = d ^ p[0] ^ p[1];
    c1 = d ^ p[1];
    return {1'b0, sym[0] ^ c0} + {1'b0, sym[1] ^ c1};
  endfunction

  // metric addition that sticks at the all-ones ceiling instead of wrapping
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // add-compare-select for all four next states; state {a,d} comes from {0,a} or {1,a}
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      cand0[ns] = sat_add(pm[ns/2],     branch_metric(sym_in, 2'(ns/2),     ns[0]));
      cand1[ns] = sat_add(pm[ns/2 + 2], branch_metric(sym_in, 2'(ns/2 + 2), ns[0]));
      if (cand1[ns] < cand0[ns]) begin
        pm_acc[ns]   = cand1[ns];
        surv_new[ns] = {surv[ns/2 + 2][TB_DEPTH-2:0], ns[0]};
      end else begin
        pm_acc[ns]   = cand0[ns];
        surv_new[ns] = {surv[ns/2][TB_DEPTH-2:0], ns[0]};
      end
    end
  end

  // normalise against the smallest new metric and pick the lowest-index zero state
  always_comb begin
    pm_min = pm_acc[0];
    for (int s = 1; s < 4; s++) begin
      if (pm_acc[s] < pm_min) pm_min = pm_acc[s];
    end
    for (int s = 0; s < 4; s++) begin
      pm_norm[s] = pm_acc[s] - pm_min;
    end
    best = 2'd3;
    for (int s = 3; s >= 0; s--) begin
      if (pm_norm[s] == '0) best = 2'(s);
    end
    fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    full_next = (fill_next == FILL_FULL);
    dec_bit   = surv_new[best][TB_DEPTH-1];
  end

  // path metrics and survivor registers advance only on accepted symbols
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 4; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_MAX;
        surv[s] <= '0;
      end
    end else if (clr) begin
      for (int s = 0; s < 4; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_MAX;
        surv[s] <= '0;
      end
    end else if (sym_valid) begin
      for (int s = 0; s < 4; s++) begin
        pm[s]   <= pm_norm[s];
        surv[s] <= surv_new[s];
      end
    end
  end

  // fill/run control with registered lock flag and decoded-bit outputs
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      fill      <= '0;
      locked    <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
    end else if (clr) begin
      state     <= FILL;
      fill      <= '0;
      locked    <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
    end else if (sym_valid) begin
      fill      <= fill_next;
      bit_valid <= full_next;
      if (full_next) bit_out <= dec_bit;
      case (state)
        FILL: begin
          if (full_next) begin
            state  <= RUN;
            locked <= 1'b1;
          end
        end
        RUN: begin
          state  <= RUN;
          locked <= 1'b1;
        end
        default: begin
          state  <= FILL;
          locked <= 1'b0;
        end
      endcase
    end else begin
      bit_valid <= 1'b0;
    end
  end

`ifdef VITERBI_ERR_CNT_EN
  logic [1:0]       dly [TB_DEPTH-1];
  logic [1:0]       enc;
  logic [1:0]       re_sym;
  logic [1:0]       miss;
  logic [1:0]       miss_cnt;
  logic [ERR_W:0]   err_sum;

  // re-encode the decision and compare against the symbol it was decided from
  always_comb begin
    re_sym[0] = dec_bit ^ enc[0] ^ enc[1];
    re_sym[1] = dec_bit ^ enc[1];
    miss      = dly[TB_DEPTH-2] ^ re_sym;
    miss_cnt  = {1'b0, miss[0]} + {1'b0, miss[1]};
    err_sum   = {1'b0, err_count} + {{(ERR_W-1){1'b0}}, miss_cnt};
  end

  // symbol delay line, local encoder state and saturating corrected-bit counter
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TB_DEPTH - 1; i++) dly[i] <= '0;
      enc       <= '0;
      err_count <= '0;
    end else if (clr) begin
      for (int i = 0; i < TB_DEPTH - 1; i++) dly[i] <= '0;
      enc       <= '0;
      err_count <= '0;
    end else if (sym_valid) begin
      dly[0] <= sym_in;
      for (int i = 1; i < TB_DEPTH - 1; i++) dly[i] <= dly[i-1];
      if (full_next) begin
        enc       <= {enc[0], dec_bit};
        err_count <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      end
    end
  end
`else
  assign err_count = '0;
`endif

endmodule
